// File: rtl/word_packer.sv
// word_packer: gathers RATIO consecutive IN_WIDTH-bit samples into one wide word behind a valid/ready output.
// Optional partial-word flush is enabled by defining WORD_PACKER_FLUSH_EN.
module word_packer #(
    parameter int IN_WIDTH = 8,
    parameter int RATIO    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [IN_WIDTH-1:0]          in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [IN_WIDTH*RATIO-1:0]    out_data,
    output logic [$clog2(RATIO+1)-1:0]   out_count,
    input  logic                         out_ready
`ifdef WORD_PACKER_FLUSH_EN
    ,
    input  logic                         flush
`endif
);

    localparam int CW  = $clog2(RATIO);
    localparam int OCW = $clog2(RATIO+1);
    localparam int AW  = IN_WIDTH*(RATIO-1);
    localparam logic [CW-1:0] LAST = CW'(RATIO-1);

    logic [CW-1:0] cnt;
    logic [AW-1:0] acc;
    logic          out_free;
    logic          cnt_last;
    logic          accept;
    logic          load_full;
    logic          flush_emit;

`ifdef WORD_PACKER_FLUSH_EN
    logic                      flush_pend;
    logic [IN_WIDTH*RATIO-1:0] flush_word;

    // Pending flush blocks input so the partial word is emitted with a stable lane count.
    always_comb begin
        out_free   = !out_valid || out_ready;
        cnt_last   = (cnt == LAST);
        in_ready   = rst && !flush_pend && (!cnt_last || out_free);
        accept     = in_valid && in_ready;
        load_full  = accept && cnt_last;
        flush_emit = flush_pend && out_free && (cnt != '0);
    end

    // Lanes at or above cnt may hold stale data from an earlier word, so they are zeroed.
    always_comb begin
        flush_word = '0;
        for (int k = 0; k < RATIO-1; k++) begin
            if (k < int'(cnt)) begin
                flush_word[k*IN_WIDTH +: IN_WIDTH] = acc[k*IN_WIDTH +: IN_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flush_pend <= 1'b0;
        end else if (flush) begin
            flush_pend <= 1'b1;
        end else if (flush_pend && (out_free || cnt == '0)) begin
            flush_pend <= 1'b0;
        end
    end
`else
    always_comb begin
        out_free   = !out_valid || out_ready;
        cnt_last   = (cnt == LAST);
        in_ready   = rst && (!cnt_last || out_free);
        accept     = in_valid && in_ready;
        load_full  = accept && cnt_last;
        flush_emit = 1'b0;
    end
`endif

    // The final lane bypasses acc and goes straight into the output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            acc <= '0;
        end else if (load_full || flush_emit) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= cnt + CW'(1);
            for (int k = 0; k < RATIO-1; k++) begin
                if (cnt == CW'(k)) begin
                    acc[k*IN_WIDTH +: IN_WIDTH] <= in_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
        end else if (load_full) begin
            out_valid <= 1'b1;
            out_data  <= {in_data, acc};
            out_count <= OCW'(RATIO);
`ifdef WORD_PACKER_FLUSH_EN
        end else if (flush_emit) begin
            out_valid <= 1'b1;
            out_data  <= flush_word;
            out_count <= OCW'(cnt);
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_word_packer.sv
// tb_word_packer: vector table, hand sequences and randomized scoreboard runs for word_packer (IN_WIDTH=8, RATIO=4).
// Flush sequences are built only when WORD_PACKER_FLUSH_EN is defined.
module tb_word_packer;

    localparam int W = 8;
    localparam int R = 4;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_ready;
    logic          out_valid;
    logic [W*R-1:0] out_data;
    logic [2:0]    out_count;
    logic          out_ready;
`ifdef WORD_PACKER_FLUSH_EN
    logic          flush;
`endif

    int checks = 0;
    int errors = 0;

    logic [W-1:0]   sample_q[$];
    logic [W*R-1:0] word_q[$];

    typedef struct {
        logic           v;
        logic [W-1:0]   d;
        logic           ordy;
        logic           exp_ir;
        logic           exp_ov;
        logic [W*R-1:0] exp_data;
        logic [2:0]     exp_cnt;
    } vec_t;

    vec_t vecs[16];

    word_packer #(.IN_WIDTH(W), .RATIO(R)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_count (out_count),
        .out_ready (out_ready)
`ifdef WORD_PACKER_FLUSH_EN
        ,
        .flush     (flush)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drives inputs just after a falling edge and lets combinational outputs settle.
    task automatic apply_stimulus(input logic v, input logic [W-1:0] d, input logic ordy);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        #1;
    endtask

    function automatic logic [W*R-1:0] pack_word(input logic [W-1:0] s0, input logic [W-1:0] s1,
                                                 input logic [W-1:0] s2, input logic [W-1:0] s3);
        logic [W*R-1:0] w;
        w = 0;
        w = w + (32'(s0) << 0);
        w = w + (32'(s1) << 8);
        w = w + (32'(s2) << 16);
        w = w + (32'(s3) << 24);
        return w;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_in_ready"},  64'(in_ready),  64'd0);
        check_output({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check_output({tag, "_out_data"},  64'(out_data),  64'd0);
        check_output({tag, "_out_count"}, 64'(out_count), 64'd0);
    endtask

    task automatic run_random(input int n_samples, input int valid_pct, input int ready_pct,
                              input bit full_rate, output int words);
        int accepted = 0;
        int cycles = 0;
        bit hold_prev = 0;
        logic [W*R-1:0] held = 0;
        words = 0;
        sample_q.delete();
        word_q.delete();
        while (accepted < n_samples && cycles < 20000) begin
            apply_stimulus(($urandom_range(99) < valid_pct), 8'($urandom), ($urandom_range(99) < ready_pct));
            if (hold_prev) begin
                check_output("hold_valid", 64'(out_valid), 64'd1);
                check_output("hold_data", 64'(out_data), 64'(held));
            end
            if (full_rate) check_output("in_ready_sustained", 64'(in_ready), 64'd1);
            if (out_valid && out_ready) begin
                if (word_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_word: got 0x%0h, expected no word", out_data);
                end else begin
                    check_output("rand_word", 64'(out_data), 64'(word_q.pop_front()));
                    check_output("rand_count", 64'(out_count), 64'd4);
                    words++;
                end
            end
            hold_prev = out_valid && !out_ready;
            held = out_data;
            if (in_valid && in_ready) begin
                sample_q.push_back(in_data);
                accepted++;
                if (sample_q.size() == R) begin
                    word_q.push_back(pack_word(sample_q[0], sample_q[1], sample_q[2], sample_q[3]));
                    sample_q.delete();
                end
            end
            @(negedge clk);
            cycles++;
        end
        if (accepted < n_samples) begin
            checks++;
            errors++;
            $display("[TB] FAIL random_timeout: got %0d samples, expected %0d", accepted, n_samples);
        end
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b0, 8'h00, 1'b1);
            if (out_valid) begin
                if (word_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_word: got 0x%0h, expected no word", out_data);
                end else begin
                    check_output("drain_word", 64'(out_data), 64'(word_q.pop_front()));
                    words++;
                end
            end
            @(negedge clk);
        end
        check_output("words_left", 64'(word_q.size()), 64'd0);
    endtask

    initial begin
        int words;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
`ifdef WORD_PACKER_FLUSH_EN
        flush     = 1'b0;
`endif

        // Basic pack, then backpressure with a load-and-drain in the same cycle.
        vecs[0]  = '{1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 32'h0,        3'd0};
        vecs[1]  = '{1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 32'h0,        3'd0};
        vecs[2]  = '{1'b1, 8'h33, 1'b1, 1'b1, 1'b0, 32'h0,        3'd0};
        vecs[3]  = '{1'b1, 8'h44, 1'b1, 1'b1, 1'b1, 32'h44332211, 3'd4};
        vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0,        3'd0};
        vecs[5]  = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 32'h0,        3'd0};
        vecs[6]  = '{1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 32'h0,        3'd0};
        vecs[7]  = '{1'b1, 8'h03, 1'b0, 1'b1, 1'b0, 32'h0,        3'd0};
        vecs[8]  = '{1'b1, 8'h04, 1'b0, 1'b1, 1'b1, 32'h04030201, 3'd4};
        vecs[9]  = '{1'b1, 8'h05, 1'b0, 1'b1, 1'b1, 32'h04030201, 3'd4};
        vecs[10] = '{1'b1, 8'h06, 1'b0, 1'b1, 1'b1, 32'h04030201, 3'd4};
        vecs[11] = '{1'b1, 8'h07, 1'b0, 1'b1, 1'b1, 32'h04030201, 3'd4};
        vecs[12] = '{1'b1, 8'h08, 1'b0, 1'b0, 1'b1, 32'h04030201, 3'd4};
        vecs[13] = '{1'b1, 8'h08, 1'b0, 1'b0, 1'b1, 32'h04030201, 3'd4};
        vecs[14] = '{1'b1, 8'h08, 1'b1, 1'b1, 1'b1, 32'h08070605, 3'd4};
        vecs[15] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0,        3'd0};

        @(negedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            apply_stimulus(vecs[i].v, vecs[i].d, vecs[i].ordy);
            check_output($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].exp_ir));
            @(negedge clk);
            check_output($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].exp_ov));
            if (vecs[i].exp_ov) begin
                check_output($sformatf("vec%0d_out_data", i), 64'(out_data), 64'(vecs[i].exp_data));
                check_output($sformatf("vec%0d_out_count", i), 64'(out_count), 64'(vecs[i].exp_cnt));
            end
        end

        run_random(400, 100, 100, 1'b1, words);
        check_output("sustained_words", 64'(words), 64'd100);
        run_random(200, 70, 50, 1'b0, words);
        check_output("random_words", 64'(words), 64'd50);

        // Reset in the middle of a word must discard the partial lanes.
        apply_stimulus(1'b1, 8'hAA, 1'b1);
        @(negedge clk);
        apply_stimulus(1'b1, 8'hBB, 1'b1);
        @(negedge clk);
        apply_stimulus(1'b0, 8'h00, 1'b1);
        rst = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        #1;
        check_reset_outputs("midreset_hold");
        rst = 1'b1;
        @(negedge clk);
        for (int i = 1; i <= 4; i++) begin
            apply_stimulus(1'b1, 8'(i), 1'b1);
            @(negedge clk);
            check_output($sformatf("post_reset_valid%0d", i), 64'(out_valid), (i == 4) ? 64'd1 : 64'd0);
        end
        check_output("post_reset_word", 64'(out_data), 64'h04030201);
        check_output("post_reset_count", 64'(out_count), 64'd4);
        apply_stimulus(1'b0, 8'h00, 1'b1);
        @(negedge clk);

`ifdef WORD_PACKER_FLUSH_EN
        apply_stimulus(1'b1, 8'h5A, 1'b1);
        @(negedge clk);
        apply_stimulus(1'b1, 8'hC3, 1'b1);
        @(negedge clk);
        flush = 1'b1;
        apply_stimulus(1'b0, 8'h00, 1'b1);
        check_output("flush_pulse_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        flush = 1'b0;
        apply_stimulus(1'b1, 8'h77, 1'b1);
        check_output("flush_pend_in_ready", 64'(in_ready), 64'd0);
        check_output("flush_pend_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        apply_stimulus(1'b0, 8'h00, 1'b1);
        check_output("flush_out_valid", 64'(out_valid), 64'd1);
        check_output("flush_out_data", 64'(out_data), 64'h0000C35A);
        check_output("flush_out_count", 64'(out_count), 64'd2);
        check_output("flush_done_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);

        apply_stimulus(1'b1, 8'hA1, 1'b1);
        @(negedge clk);
        apply_stimulus(1'b1, 8'hB2, 1'b1);
        @(negedge clk);
        apply_stimulus(1'b1, 8'hC3, 1'b1);
        @(negedge clk);
        flush = 1'b1;
        apply_stimulus(1'b1, 8'hD4, 1'b1);
        check_output("boundary_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        flush = 1'b0;
        apply_stimulus(1'b0, 8'h00, 1'b1);
        check_output("boundary_out_valid", 64'(out_valid), 64'd1);
        check_output("boundary_out_data", 64'(out_data), 64'hD4C3B2A1);
        check_output("boundary_out_count", 64'(out_count), 64'd4);
        check_output("boundary_pend_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        apply_stimulus(1'b0, 8'h00, 1'b1);
        check_output("boundary_no_extra_word", 64'(out_valid), 64'd0);
        check_output("boundary_in_ready_back", 64'(in_ready), 64'd1);
        @(negedge clk);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
